// File: rtl/tm1638_key_if.sv
// TM1638 key-reader bus: scan request/result handshake plus the split STB/SCLK/DIO pad signals.
interface tm1638_key_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  keys;
  logic [31:0] raw_data;
  logic        stb;
  logic        sclk;
  logic        dio_out;
  logic        dio_oe;
  logic        dio_in;

  modport slave (
    input  start, dio_in,
    output busy, done, keys, raw_data, stb, sclk, dio_out, dio_oe
  );

  modport master (
    output start, dio_in,
    input  busy, done, keys, raw_data, stb, sclk, dio_out, dio_oe
  );
endinterface

// File: rtl/tm1638_key_reader.sv
// TM1638 key scanner: sends the read-key command, turns DIO around, shifts in the 4 key
// bytes LSB first and publishes the 8 front-panel keys with a one-cycle done pulse.
module tm1638_key_reader #(
  parameter int unsigned HALF_DIV = 25,
  parameter int unsigned WAIT_CYC = 100,
  parameter logic [7:0]  CMD_READ = 8'h42
) (
  input logic          clk_50M,
  input logic          reset,
  tm1638_key_if.slave  bus
);

  localparam int unsigned CNT_MAX = (HALF_DIV > WAIT_CYC) ? HALF_DIV : WAIT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned HALF_W  = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CMD,
    S_WAIT,
    S_READ,
    S_STOP,
    S_DONE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [HALF_W-1:0]   half;
  logic [HALF_W-1:0]   half_nxt;
  logic [31:0]         shift;
  logic [7:0]          key_map;
  logic                half_end;
  logic                wait_end;

  always_comb begin
    half_nxt = half + HALF_W'(1);
    half_end = (cnt == CNT_W'(HALF_DIV - 1));
    wait_end = (cnt == CNT_W'(WAIT_CYC - 1));
  end

  // Bit 0 of each key byte is the low key of its pair, bit 4 the high key.
  always_comb begin
    key_map = 8'h00;
    for (int b = 0; b < 4; b++) begin
      key_map[b]     = shift[8*b];
      key_map[b + 4] = shift[8*b + 4];
    end
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      half         <= '0;
      shift        <= '0;
      bus.stb      <= 1'b1;
      bus.sclk     <= 1'b1;
      bus.dio_oe   <= 1'b0;
      bus.dio_out  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.keys     <= '0;
      bus.raw_data <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state       <= S_SETUP;
            cnt         <= '0;
            bus.busy    <= 1'b1;
            bus.stb     <= 1'b0;
            bus.sclk    <= 1'b1;
            bus.dio_oe  <= 1'b1;
            bus.dio_out <= CMD_READ[0];
          end
        end
        S_SETUP: begin
          if (half_end) begin
            state       <= S_CMD;
            cnt         <= '0;
            half        <= '0;
            bus.sclk    <= 1'b0;
            bus.dio_out <= CMD_READ[0];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_CMD: begin
          if (half_end) begin
            cnt <= '0;
            if (half == HALF_W'(15)) begin
              // Release DIO together with the last rising half so the chip can take over.
              state       <= S_WAIT;
              half        <= '0;
              bus.sclk    <= 1'b1;
              bus.dio_oe  <= 1'b0;
              bus.dio_out <= 1'b0;
            end else begin
              half     <= half_nxt;
              bus.sclk <= half_nxt[0];
              if (!half_nxt[0]) begin
                bus.dio_out <= CMD_READ[half_nxt[3:1]];
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (wait_end) begin
            state    <= S_READ;
            cnt      <= '0;
            half     <= '0;
            bus.sclk <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_READ: begin
          if (half_end) begin
            cnt <= '0;
            // Sample late in the high phase, well after the chip updated DIO on the falling edge.
            if (half[0]) begin
              shift[half[5:1]] <= bus.dio_in;
            end
            if (half == HALF_W'(63)) begin
              state    <= S_STOP;
              half     <= '0;
              bus.sclk <= 1'b1;
            end else begin
              half     <= half_nxt;
              bus.sclk <= half_nxt[0];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (half_end) begin
            state        <= S_DONE;
            cnt          <= '0;
            bus.stb      <= 1'b1;
            bus.done     <= 1'b1;
            bus.raw_data <= shift;
            bus.keys     <= key_map;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
